// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war game.
// Holds round FSM states, verdict encoding and default round timing.
package tug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_SAMPLE,
    S_EXIT
  } state_e;

  // One-hot verdict, packed as {tie, right, left}
  typedef logic [2:0] res_t;

  localparam res_t RES_NONE  = 3'b000;
  localparam res_t RES_LEFT  = 3'b001;
  localparam res_t RES_RIGHT = 3'b010;
  localparam res_t RES_TIE   = 3'b100;

  localparam int ARM_CYCLES_DEF   = 100_000_000;
  localparam int ROUND_CYCLES_DEF = 250_000_000;

  function automatic res_t verdict(
    input logic tie,
    input logic right
  );
    if (tie)
      return RES_TIE;
    else if (right)
      return RES_RIGHT;
    else
      return RES_LEFT;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Non-wrapping down-counter used for the arm and round windows.
// expired flags a count of zero; load has priority over decrement.
module round_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/speed_round_ctrl.sv
// Speed-round sequencer: arms, runs and closes a push-counter round,
// then reports a registered one-hot verdict to the game FSM.
module speed_round_ctrl
  import tug_pkg::*;
#(
  parameter int ARM_CYCLES   = ARM_CYCLES_DEF,
  parameter int ROUND_CYCLES = ROUND_CYCLES_DEF,
  parameter int CNT_W        = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic speed_tie,
  input  logic speed_right,
  output logic speedRound,
  output logic speedExit,
  output logic arming,
  output logic busy,
  output logic res_valid,
  output logic res_left,
  output logic res_right,
  output logic res_tie
);

  localparam logic [CNT_W-1:0] ARM_LD = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RND_LD = CNT_W'(ROUND_CYCLES - 1);

  state_e state_q, state_d;
  res_t   res_q, res_d;
  logic   round_q, exit_q, arming_q, busy_q, valid_q;
  logic   tmr_load, tmr_en, tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  round_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARM;
          tmr_load = 1'b1;
          tmr_val  = ARM_LD;
          res_d    = RES_NONE;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_EXIT;
        end else if (tmr_exp) begin
          state_d  = S_RUN;
          tmr_load = 1'b1;
          tmr_val  = RND_LD;
        end
      end
      S_RUN: begin
        if (abort)
          state_d = S_EXIT;
        else if (tmr_exp)
          state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        state_d = S_EXIT;
        res_d   = verdict(speed_tie, speed_right);
      end
      S_EXIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_en = (state_q == S_ARM) || (state_q == S_RUN);

  // Outputs decode the next state so they are flops, not logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      res_q    <= RES_NONE;
      round_q  <= 1'b0;
      exit_q   <= 1'b0;
      arming_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      round_q  <= (state_d == S_RUN);
      exit_q   <= (state_d == S_EXIT);
      arming_q <= (state_d == S_ARM);
      busy_q   <= (state_d != S_IDLE);
      valid_q  <= (state_q == S_SAMPLE);
    end
  end

  assign speedRound = round_q;
  assign speedExit  = exit_q;
  assign arming     = arming_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign res_left   = res_q[0];
  assign res_right  = res_q[1];
  assign res_tie    = res_q[2];

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Bench for speed_round_ctrl: random push-counter rounds compared
// every cycle against a timeline model built from round arithmetic.
module tb_speed_round_ctrl;

  localparam int ARM   = 4;
  localparam int ROUND = 10;

  logic clk = 1'b0;
  logic rst, start, abort, speed_tie, speed_right;
  logic speedRound, speedExit, arming, busy;
  logic res_valid, res_left, res_right, res_tie;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: s = edge that accepted start, exit_c = edge entering exit
  int s = -1;
  int exit_c = -10;
  bit aborted = 1'b0;
  logic [2:0] res_exp = 3'b000;
  int lcnt = 0;
  int rcnt = 0;
  bit force_both = 1'b0;

  always #5 clk = ~clk;

  assign speed_tie   = force_both | (lcnt == rcnt);
  assign speed_right = force_both | (rcnt > lcnt);

  speed_round_ctrl #(
    .ARM_CYCLES  (ARM),
    .ROUND_CYCLES(ROUND),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .speed_tie  (speed_tie),
    .speed_right(speed_right),
    .speedRound (speedRound),
    .speedExit  (speedExit),
    .arming     (arming),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_left   (res_left),
    .res_right  (res_right),
    .res_tie    (res_tie)
  );

  function automatic bit active(int n);
    return (s >= 0) && (n >= s) && (n <= exit_c);
  endfunction

  function automatic logic [7:0] exp_vec(int n);
    bit act;
    bit pre;
    int k;
    act = active(n);
    pre = act && (n < exit_c);
    k = n - s;
    return {pre && (k >= ARM) && (k < ARM + ROUND),
            act && (n == exit_c),
            pre && (k < ARM),
            act,
            act && (n == exit_c) && !aborted,
            res_exp};
  endfunction

  function automatic logic [2:0] intent(int l, int r, bit fb);
    if (fb || l == r) return 3'b100;
    if (r > l) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [7:0] obs;
    obs = {speedRound, speedExit, arming, busy,
           res_valid, res_tie, res_right, res_left};
    check($sformatf("cyc%0d", cyc), 32'(obs), 32'(exp_vec(cyc)));
  endtask

  task automatic tick();
    bit was_act;
    was_act = active(cyc);
    if (rst) begin
      if (abort && was_act && cyc < exit_c && (cyc - s) < ARM + ROUND) begin
        exit_c  = cyc + 1;
        aborted = 1'b1;
      end
      if (!aborted && s >= 0 && cyc + 1 == exit_c)
        res_exp = intent(lcnt, rcnt, force_both);
      if (start && !was_act) begin
        s       = cyc + 1;
        exit_c  = s + ARM + ROUND + 1;
        aborted = 1'b0;
        res_exp = 3'b000;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic run_round(int L, int R, bit fb, bit repulse,
                           bit with_ab, int abort_k);
    int s0;
    int nrun;
    int exit_seen;
    int k;
    int rem;
    lcnt = 0;
    rcnt = 0;
    force_both = fb;
    start = 1'b1;
    abort = with_ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
    s0 = cyc;
    nrun = 0;
    exit_seen = -1;
    for (int i = 0; i < ARM + ROUND + 2; i++) begin
      k = cyc - s0;
      if (speedRound) nrun++;
      if (speedExit && exit_seen < 0) exit_seen = cyc;
      start = repulse && (k == 1 || k == ARM + 3);
      abort = (abort_k >= 0) && (k == abort_k);
      if (k >= ARM && k < ARM + ROUND) begin
        rem = ARM + ROUND - k;
        if (lcnt < L && (($urandom % 2) == 1 || L - lcnt >= rem)) lcnt++;
        if (rcnt < R && (($urandom % 2) == 1 || R - rcnt >= rem)) rcnt++;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_k < 0) begin
      check("round_len", 32'(nrun), 32'(ROUND));
      check("exit_lat", 32'(exit_seen - s0), 32'(ARM + ROUND + 1));
      check("res_final", 32'({res_tie, res_right, res_left}),
            32'(intent(L, R, fb)));
    end else begin
      check("abort_exit", 32'(exit_seen - s0), 32'(abort_k + 1));
      check("abort_res", 32'({res_valid, res_tie, res_right, res_left}), 32'd0);
    end
  endtask

  initial begin
    int L;
    int R;
    int ak;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    run_round(3, 2, 1'b0, 1'b0, 1'b0, -1);
    run_round(3, 3, 1'b0, 1'b0, 1'b0, -1);
    run_round(3, 4, 1'b0, 1'b0, 1'b0, -1);
    run_round(1, 0, 1'b1, 1'b0, 1'b0, -1);
    repeat (3) tick();

    run_round(2, 1, 1'b0, 1'b0, 1'b0, ARM + 2);
    run_round(0, 2, 1'b0, 1'b1, 1'b0, -1);
    run_round(4, 1, 1'b0, 1'b0, 1'b1, -1);
    run_round(1, 5, 1'b0, 1'b0, 1'b0, 1);

    // Kill a round mid-run with an asynchronous reset
    lcnt = 0;
    rcnt = 0;
    force_both = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (ARM + 3) tick();
    #2 rst = 1'b0;
    #1;
    check("async_rst",
          32'({speedRound, speedExit, arming, busy,
               res_valid, res_tie, res_right, res_left}), 32'd0);
    s = -1;
    exit_c = -10;
    aborted = 1'b0;
    res_exp = 3'b000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    run_round(2, 2, 1'b0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 8; n++) begin
      L = $urandom_range(0, 5);
      R = $urandom_range(0, 5);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ARM + ROUND - 1) : -1;
      run_round(L, R, ($urandom_range(0, 5) == 0), ($urandom % 2 == 1),
                ($urandom % 2 == 1), ak);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
